// File: rtl/expr_lane_pkg.sv
// Shared opcode encodings and defaults for the expression lane pipeline.
package expr_lane_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'd0;
  localparam op_t OP_SUB  = 3'd1;
  localparam op_t OP_LT   = 3'd2;
  localparam op_t OP_EQ   = 3'd3;
  localparam op_t OP_SHR  = 3'd4;
  localparam op_t OP_NEG  = 3'd5;
  localparam op_t OP_SEL  = 3'd6;
  localparam op_t OP_RXOR = 3'd7;

  localparam logic [5:0] DEFAULT_SIGNED_MASK = 6'b111000;

endpackage

// File: rtl/expr_lane_alu.sv
// Single combinational expression lane; signedness is fixed at elaboration.
module expr_lane_alu
  import expr_lane_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter bit SIGNED = 1'b0
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOSTNEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   WLIM    = (WIDTH+1)'(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] neg_a;
  logic [WIDTH-1:0] neg_b;
  logic [WIDTH-1:0] shr;
  logic             lt;
  logic             add_sovf;
  logic             sub_sovf;

  // The extra top bit of sum/dif is the unsigned carry/borrow.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  assign neg_a = ~a + ONE;
  assign neg_b = ~b + ONE;

  assign add_sovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_sovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    lt = 1'b0;
    if (SIGNED) lt = $signed(a) < $signed(b);
    else        lt = a < b;
  end

  // Oversized shift amounts saturate to sign fill (signed) or zero (unsigned).
  always_comb begin
    shr = '0;
    if ({1'b0, b} >= WLIM) begin
      shr = SIGNED ? {WIDTH{a[WIDTH-1]}} : '0;
    end else if (SIGNED) begin
      shr = $unsigned($signed(a) >>> b);
    end else begin
      shr = a >> b;
    end
  end

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = sum[WIDTH-1:0];
        ovf = SIGNED ? add_sovf : sum[WIDTH];
      end
      OP_SUB: begin
        y   = dif[WIDTH-1:0];
        ovf = SIGNED ? sub_sovf : dif[WIDTH];
      end
      OP_LT:   y = {{(WIDTH-1){1'b0}}, lt};
      OP_EQ:   y = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SHR:  y = shr;
      OP_NEG: begin
        y   = neg_a;
        ovf = SIGNED && (a == MOSTNEG);
      end
      OP_SEL:  y = (|a) ? b : neg_b;
      OP_RXOR: y = {{(WIDTH-1){1'b0}}, ^(a ^ b)};
      default: begin
        y   = '0;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/expr_lane_pipe.sv
// Multi-lane expression evaluator behind a valid/ready elastic pipeline.
module expr_lane_pipe
  import expr_lane_pkg::*;
#(
  parameter int               LANES       = 6,
  parameter int               WIDTH       = 6,
  parameter int               STAGES      = 2,
  parameter logic [LANES-1:0] SIGNED_MASK = DEFAULT_SIGNED_MASK,
  parameter int               CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  op_t                    in_op,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_y,
  output logic [LANES-1:0]       out_ovf,
  output logic [CNT_W-1:0]       out_count
);

  logic [LANES*WIDTH-1:0] alu_y;
  logic [LANES-1:0]       alu_ovf;

  logic [STAGES-1:0]      vld;
  logic [STAGES-1:0]      ld;
  logic [LANES*WIDTH-1:0] stg_y   [STAGES];
  logic [LANES-1:0]       stg_ovf [STAGES];
  logic [CNT_W-1:0]       cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    expr_lane_alu #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED_MASK[i])
    ) u_alu (
      .op  (in_op),
      .a   (in_a[i*WIDTH +: WIDTH]),
      .b   (in_b[i*WIDTH +: WIDTH]),
      .y   (alu_y[i*WIDTH +: WIDTH]),
      .ovf (alu_ovf[i])
    );
  end

  // Ready ripples back from the consumer; a scalar carries it so ld is never read here.
  always_comb begin
    logic chain;
    ld    = '0;
    chain = !vld[STAGES-1] || out_ready;
    ld[STAGES-1] = chain;
    for (int i = STAGES-2; i >= 0; i--) begin
      chain = !vld[i] || chain;
      ld[i] = chain;
    end
  end

  assign in_ready = ld[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      cnt <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stg_y[i]   <= '0;
        stg_ovf[i] <= '0;
      end
    end else begin
      if (ld[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          stg_y[0]   <= alu_y;
          stg_ovf[0] <= alu_ovf;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (ld[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            stg_y[i]   <= stg_y[i-1];
            stg_ovf[i] <= stg_ovf[i-1];
          end
        end
      end
      if (vld[STAGES-1] && out_ready) cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_y     = stg_y[STAGES-1];
  assign out_ovf   = stg_ovf[STAGES-1];
  assign out_count = cnt;

endmodule

// File: tb/tb_expr_lane_pipe.sv
// Directed checks for expr_lane_pipe at default parameters.
module tb_expr_lane_pipe;
  import expr_lane_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  op_t         in_op;
  logic [35:0] in_a;
  logic [35:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_y;
  logic [5:0]  out_ovf;
  logic [15:0] out_count;

  int nvec = 0;
  int nerr = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  expr_lane_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pk(input logic [5:0] l5, l4, l3, l2, l1, l0);
    return {l5, l4, l3, l2, l1, l0};
  endfunction

  // One transaction through an empty pipe with out_ready held high.
  task automatic run_one(input string tag, input op_t op, input logic [35:0] a, b,
                         input logic [35:0] ey, input logic [5:0] eovf);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_y"}, out_y, ey);
    chk({tag, "_ovf"}, out_ovf, eovf);
    exp_count++;
    @(negedge clk);
    chk({tag, "_cnt"}, out_count, exp_count);
    chk({tag, "_drain"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = OP_ADD; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_y", out_y, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_cnt", out_count, 0);
    chk("rst_rdy", in_ready, 1);

    run_one("add", OP_ADD, pk(6'h00, 6'h00, 6'h1F, 6'h00, 6'h00, 6'h3F),
            pk(6'h00, 6'h00, 6'h01, 6'h00, 6'h00, 6'h01),
            pk(6'h00, 6'h00, 6'h20, 6'h00, 6'h00, 6'h00), 6'b001001);
    run_one("lt", OP_LT, {6{6'h3F}}, {6{6'h01}},
            pk(6'h01, 6'h01, 6'h01, 6'h00, 6'h00, 6'h00), 6'b000000);
    run_one("shr2", OP_SHR, {6{6'h20}}, {6{6'h02}},
            pk(6'h38, 6'h38, 6'h38, 6'h08, 6'h08, 6'h08), 6'b000000);
    run_one("shr7", OP_SHR, {6{6'h20}}, {6{6'h07}},
            pk(6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00), 6'b000000);
    run_one("neg", OP_NEG, {6{6'h20}}, {6{6'h00}}, {6{6'h20}}, 6'b111000);
    run_one("sel", OP_SEL, {6{6'h00}}, {6{6'h05}}, {6{6'h3B}}, 6'b000000);
    run_one("sub", OP_SUB, {6{6'h00}}, {6{6'h01}}, {6{6'h3F}}, 6'b000111);
    run_one("subs", OP_SUB, {6{6'h20}}, {6{6'h01}}, {6{6'h1F}}, 6'b111000);
    run_one("eq", OP_EQ, pk(6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05),
            pk(6'h05, 6'h04, 6'h05, 6'h05, 6'h06, 6'h05),
            pk(6'h01, 6'h00, 6'h01, 6'h01, 6'h00, 6'h01), 6'b000000);
    run_one("rxor", OP_RXOR, pk(6'h07, 6'h01, 6'h03, 6'h07, 6'h01, 6'h03),
            pk(6'h00, 6'h02, 6'h00, 6'h00, 6'h02, 6'h00),
            pk(6'h01, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00), 6'b000000);

    // Backpressure: three ADDs offered against a stalled consumer.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = OP_ADD;
    in_a = {6{6'h01}}; in_b = {6{6'h01}};
    @(negedge clk);
    chk("bp_rdy0", in_ready, 1);
    @(posedge clk); #1;
    in_a = {6{6'h10}}; in_b = {6{6'h10}};
    @(negedge clk);
    chk("bp_rdy1", in_ready, 1);
    @(posedge clk); #1;
    in_a = {6{6'h3F}}; in_b = {6{6'h3F}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_full", in_ready, 0);
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_y", out_y, {6{6'h02}});
      chk("bp_hold_ovf", out_ovf, 6'b000000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rdy_rel", in_ready, 1);
    chk("bp_y0", out_y, {6{6'h02}});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_vld1", out_valid, 1);
    chk("bp_y1", out_y, {6{6'h20}});
    chk("bp_ovf1", out_ovf, 6'b111000);
    @(negedge clk);
    chk("bp_vld2", out_valid, 1);
    chk("bp_y2", out_y, {6{6'h3E}});
    chk("bp_ovf2", out_ovf, 6'b000111);
    @(negedge clk);
    exp_count += 3;
    chk("bp_empty", out_valid, 0);
    chk("bp_cnt", out_count, exp_count);

    // Reset with two transactions in flight; the offer during reset must be ignored.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = OP_ADD;
    in_a = {6{6'h11}}; in_b = {6{6'h01}};
    @(posedge clk); #1;
    in_a = {6{6'h12}};
    @(posedge clk); #1;
    in_a = {6{6'h13}};
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    exp_count = 0;
    chk("rst2_vld", out_valid, 0);
    chk("rst2_cnt", out_count, 0);
    chk("rst2_rdy", in_ready, 1);
    chk("rst2_y", out_y, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst2_drop", out_valid, 0);
    end
    run_one("post_rst", OP_ADD, {6{6'h03}}, {6{6'h04}}, {6{6'h07}}, 6'b000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/expr_lane_pipe.md
Name: expr_lane_pipe

Overview:
- Parametrised, pipelined successor to the flat combinational expression blocks.
- Evaluates one opcode per transaction across LANES independent operand lanes. Each lane is signed or unsigned per a static mask.
- Results are registered through a valid/ready elastic pipeline of STAGES depth and concatenated onto one output bus with per-lane overflow flags.
- Used as a regression target for mixed-signedness arithmetic, shifts and compares under backpressure.

Parameters:
- LANES, 6, number of operand lanes.
- WIDTH, 6, bits per lane operand and result (min 2).
- STAGES, 2, pipeline register stages, legal 1..4.
- SIGNED_MASK, 6'b111000, LANES bits; bit i=1 makes lane i two's-complement signed.
- CNT_W, 16, width of completed-transaction counter.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  transaction offered.
- in_ready  out  1  block can accept this cycle.
- in_op  in  3  opcode, shared by all lanes.
- in_a  in  LANES*WIDTH  lane i operand A at bits [i*WIDTH +: WIDTH].
- in_b  in  LANES*WIDTH  lane i operand B, same packing.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_y  out  LANES*WIDTH  lane results, same packing.
- out_ovf  out  LANES  per-lane overflow flag.
- out_count  out  CNT_W  number of output handshakes since reset.

Behaviour:
- Input handshake fires when in_valid && in_ready; output handshake fires when out_valid && out_ready.
- Compute is combinational on the inputs and captured into stage 0. Stages 1..STAGES-1 are pure delay. out_* are driven from the last stage.
- Stage i loads when its valid bit is 0 or stage i+1 is loading (for the last stage, when out_ready=1).
- in_ready = stage-0 load condition. The ready chain is combinational.
- Latency: a transaction accepted at the edge ending cycle t gives out_valid=1 in cycle t+STAGES when out_ready stays 1. Throughput is 1 per cycle.
- Order is strictly preserved. No drops and no duplicates.
- A stalled output holds out_y, out_ovf and out_valid stable until the handshake.
- Opcodes, per lane; s = lane signedness; results truncated to WIDTH:
  - 0 ADD: y=a+b. ovf = s ? signed overflow : carry-out.
  - 1 SUB: y=a-b. ovf = s ? signed overflow : borrow (a<b unsigned).
  - 2 LT: y={0..,a<b}, compared signed if s. ovf=0.
  - 3 EQ: y={0..,a==b}. ovf=0.
  - 4 SHR: shift amount = b as unsigned. y = s ? a>>>amt : a>>amt.
    - amt>=WIDTH: signed gives all copies of the sign bit, unsigned gives 0. ovf=0.
  - 5 NEG: y=-a. ovf = s && a==most-negative; ovf=0 for unsigned lanes.
  - 6 SEL: y = (|a) ? b : -b. ovf=0.
  - 7 RXOR: y={0..,^(a^b)}. ovf=0.
- out_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- Reset, synchronous, takes priority over everything:
  - all stage valid bits, data and ovf registers, and out_count go to 0.
  - out_valid=0 and out_y=0 in the cycle after reset is sampled.
  - in-flight transactions are discarded and never emitted.
  - in_ready=1 from the first cycle after reset deasserts.
- in_valid asserted during reset is ignored.
- Simultaneous input and output handshake on a full pipeline is legal and keeps full throughput.

Decomposition:
- Package expr_lane_pkg:
  - opcode localparams OP_ADD..OP_RXOR, 3 bits.
  - op_t typedef.
  - default SIGNED_MASK constant.
- Sub-module expr_lane_alu: purely combinational single lane.
  - parameters WIDTH and SIGNED.
  - ports op, a, b, y, ovf.
  - instantiated LANES times via generate.
- Top level holds only the pipeline registers, ready chain and counter.

Test Plan:
- ADD at defaults, out_ready=1, lanes 0 and 3 with a=6'h3F/b=1 and a=6'h1F/b=1 -> lane0 y=0, ovf=1; lane3 y=6'h20, ovf=1; out_valid exactly 2 cycles after accept.
- LT with a=6'h3F, b=1 on all lanes -> lanes 0-2 y=0; lanes 3-5 y=1; out_ovf=0.
- SHR with a=6'h20 on all lanes:
  - b=2 -> lanes 0-2 y=6'h08; lanes 3-5 y=6'h38.
  - b=7 -> lanes 0-2 y=0; lanes 3-5 y=6'h3F.
- NEG a=6'h20: lane3 y=6'h20, ovf=1; lane0 y=6'h20, ovf=0. SEL a=0, b=5 -> y=6'h3B.
- Backpressure, STAGES=2, out_ready=0, in_valid held with 3 distinct ADDs:
  - exactly 2 accepted, then in_ready=0, and out_y holds the first result stably.
  - raise out_ready -> 3 results in order on consecutive cycles; out_count=3.
- Reset for 1 cycle with 2 transactions in flight:
  - next cycle out_valid=0, out_count=0, in_ready=1.
  - dropped results never appear.
  - new transaction completes normally with out_count=1.
